// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of one single-ported data memory.
// Latency: grant and memory access are combinational; read data is registered (1 cycle).
// Backpressure: a losing port sees gntN=0 and must hold its request until granted.
// Ports: CLK/RST; per port reqN/weN/addrN/wdN/lockN in, gntN/rdN/rvalidN out;
//        mem_A/mem_WE/mem_WD to the memory, mem_RD (combinational read) from it.
// Option: define DMARB_LOCK_EN to build the ARB/LOCK0/LOCK1 grant-lock FSM;
//         without it lock0/lock1 are ignored and arbitration is pure round-robin.
module data_mem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_WD,
    input  logic [DATA_W-1:0] mem_RD
);

    // last_q = 1 means port 1 was granted most recently, so port 0 wins the next tie.
    logic              last_q, last_d;
    logic              g0, g1;
    logic [DATA_W-1:0] rd0_q, rd1_q;
    logic              rvalid0_q, rvalid1_q;

`ifdef DMARB_LOCK_EN
    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;      // consecutive grants to the lock owner
    logic       hold0, hold1;
    logic       cnt_full;
`else
    logic       unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (req0 && req1) begin
            g0 = last_q;
            g1 = ~last_q;
        end else begin
            g0 = req0;
            g1 = req1;
        end
`ifdef DMARB_LOCK_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold0    = (state_q == LOCK0) && req0;
        hold1    = (state_q == LOCK1) && req1;
        cnt_full = (9'(cnt_q) + 9'd1) >= 9'(LOCK_MAX);
        if (hold0) begin
            g0 = 1'b1;
            g1 = 1'b0;
            if (!lock0 || cnt_full) begin
                state_d = ARB;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (hold1) begin
            g0 = 1'b0;
            g1 = 1'b1;
            if (!lock1 || cnt_full) begin
                state_d = ARB;
                cnt_d   = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            // Plain round-robin cycle; an owner that dropped its request lands here
            // too, so the other port is served without a dead cycle. After a
            // LOCK_MAX exit last_q points at the owner, so the other port wins.
            state_d = ARB;
            cnt_d   = 8'd0;
            if (g0 && lock0) begin
                state_d = LOCK0;
                cnt_d   = 8'd1;
            end else if (g1 && lock1) begin
                state_d = LOCK1;
                cnt_d   = 8'd1;
            end
        end
`endif
    end

    // Reset gates the grants combinationally so nothing reaches the memory in reset.
    assign gnt0   = g0 & ~RST;
    assign gnt1   = g1 & ~RST;
    assign last_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);

    always_comb begin
        mem_A  = '0;
        mem_WE = 1'b0;
        mem_WD = '0;
        if (gnt0) begin
            mem_A  = addr0;
            mem_WE = we0;
            mem_WD = wd0;
        end else if (gnt1) begin
            mem_A  = addr1;
            mem_WE = we1;
            mem_WD = wd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q    <= 1'b1;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= gnt0 && !we0;
            rvalid1_q <= gnt1 && !we1;
            if (gnt0 && !we0) rd0_q <= mem_RD;
            if (gnt1 && !we1) rd1_q <= mem_RD;
        end
    end

`ifdef DMARB_LOCK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ARB;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign rd0     = rd0_q;
    assign rd1     = rd1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed table, corner sequences and random traffic for data_mem_arbiter.
// Latency: checks grants mid-cycle and read data one edge after a granted read.
// Backpressure: losing requests are simply re-evaluated by the reference model.
module tb_data_mem_arbiter;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int LOCK_MAX = 8;

    logic              CLK, RST;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_WE;
    logic [DATA_W-1:0] rd0, rd1, mem_WD, mem_RD;
    logic [ADDR_W-1:0] mem_A;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rd0(rd0), .rd1(rd1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    // Data memory attached to the arbiter.
    logic [DATA_W-1:0] mem [64];
    always @(posedge CLK) if (mem_WE) mem[mem_A] <= mem_WD;
    assign mem_RD = mem[mem_A];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] sh [64];      // expected memory contents
    int                m_last;       // port granted most recently
    int                m_owner;      // lock owner, -1 when none
    int                m_cnt;        // grants given to the current owner
    logic [1:0]        m_rv;
    logic [DATA_W-1:0] m_rd [2];

    task automatic model_reset();
        m_last  = 1;
        m_owner = -1;
        m_cnt   = 0;
        m_rv    = 2'b00;
        m_rd[0] = '0;
        m_rd[1] = '0;
    endtask

    function automatic int mgrant(input logic r0, input logic r1);
        if (m_owner == 0 && r0) return 0;
        if (m_owner == 1 && r1) return 1;
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    typedef struct {
        logic              r0, w0, l0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              r1, w1, l1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
    } stim_t;

    // One clock cycle: apply stimulus, check combinational side, step the model at
    // the edge, then check registered read outputs.
    task automatic do_cycle(input stim_t s, output int g);
        logic [ADDR_W-1:0] ea;
        logic              ewe;
        logic [DATA_W-1:0] ewd;
        logic [1:0]        r, l;
        req0 = s.r0; we0 = s.w0; addr0 = s.a0; wd0 = s.d0; lock0 = s.l0;
        req1 = s.r1; we1 = s.w1; addr1 = s.a1; wd1 = s.d1; lock1 = s.l1;
        #1;
        g   = mgrant(s.r0, s.r1);
        ea  = '0; ewe = 1'b0; ewd = '0;
        if (g == 0) begin ea = s.a0; ewe = s.w0; ewd = s.d0; end
        if (g == 1) begin ea = s.a1; ewe = s.w1; ewd = s.d1; end
        chk1("gnt0", gnt0, g == 0);
        chk1("gnt1", gnt1, g == 1);
        chk32("mem_A", 32'(mem_A), 32'(ea));
        chk1("mem_WE", mem_WE, ewe);
        chk32("mem_WD", mem_WD, ewd);
        @(posedge CLK);
        r    = {s.r1, s.r0};
        l    = {s.l1, s.l0};
        m_rv = 2'b00;
        if (g >= 0) begin
            if (ewe) sh[ea] = ewd;
            else begin
                m_rv[g] = 1'b1;
                m_rd[g] = sh[ea];
            end
            m_last = g;
        end
`ifdef DMARB_LOCK_EN
        if (m_owner >= 0 && !r[m_owner]) m_owner = -1;
        if (g >= 0) begin
            if (g == m_owner) begin
                m_cnt++;
                if (!l[g] || m_cnt >= LOCK_MAX) m_owner = -1;
            end else if (l[g]) begin
                m_owner = g;
                m_cnt   = 1;
            end
        end
`else
        if (r == 2'b11 && l == 2'b11) m_cnt = 0;
`endif
        #1;
        chk1("rvalid0", rvalid0, m_rv[0]);
        chk1("rvalid1", rvalid1, m_rv[1]);
        chk32("rd0", rd0, m_rd[0]);
        chk32("rd1", rd1, m_rd[1]);
        if (ewe) chk32("mem_written", mem[ea], sh[ea]);
    endtask

    typedef struct {
        stim_t             s;
        int                eg;
        logic              erv0, erv1;
        logic [DATA_W-1:0] erd0, erd1;
    } vec_t;

    function automatic stim_t mk(input logic r0, input logic w0, input int a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input int a1, input logic [31:0] d1);
        stim_t s;
        s.r0 = r0; s.w0 = w0; s.a0 = 6'(a0); s.d0 = d0; s.l0 = 1'b0;
        s.r1 = r1; s.w1 = w1; s.a1 = 6'(a1); s.d1 = d1; s.l1 = 1'b0;
        return s;
    endfunction

    vec_t  tbl [7];
    stim_t st;
    int    g;
    int    exp_seq [12];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            sh[i]  = '0;
        end
        model_reset();
        tbl[0] = '{mk(1, 1, 5, 32'hDEAD, 0, 0, 0, 0),         0, 1'b0, 1'b0, 32'h0,    32'h0};
        tbl[1] = '{mk(1, 0, 5, 0,        0, 0, 0, 0),         0, 1'b1, 1'b0, 32'hDEAD, 32'h0};
        tbl[2] = '{mk(0, 0, 0, 0,        0, 0, 0, 0),        -1, 1'b0, 1'b0, 32'hDEAD, 32'h0};
        tbl[3] = '{mk(1, 0, 3, 0,        1, 1, 3, 32'h1234),  1, 1'b0, 1'b0, 32'hDEAD, 32'h0};
        tbl[4] = '{mk(1, 0, 3, 0,        0, 0, 0, 0),         0, 1'b1, 1'b0, 32'h1234, 32'h0};
        tbl[5] = '{mk(1, 0, 3, 0,        1, 0, 5, 0),         1, 1'b0, 1'b1, 32'h1234, 32'hDEAD};
        tbl[6] = '{mk(0, 0, 0, 0,        0, 0, 0, 0),        -1, 1'b0, 1'b0, 32'h1234, 32'hDEAD};

        // Reset with a write request pending: nothing may reach the memory.
        RST = 1'b1;
        st  = mk(1, 1, 2, 32'hFFFF, 1, 1, 4, 32'hEEEE);
        req0 = st.r0; we0 = st.w0; addr0 = st.a0; wd0 = st.d0; lock0 = 1'b0;
        req1 = st.r1; we1 = st.w1; addr1 = st.a1; wd1 = st.d1; lock1 = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_mem_WE", mem_WE, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk32("rst_rd0", rd0, 32'h0);
        chk32("rst_rd1", rd1, 32'h0);
        chk32("rst_nowrite", mem[2], 32'h0);
        RST = 1'b0;

        // Contention straight after reset alternates starting with port 0.
        exp_seq = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            do_cycle(mk(1, 0, 0, 0, 1, 0, 1, 0), g);
            chk32("rr_order", 32'(g), 32'(exp_seq[i]));
        end

        // Directed write/read/same-address table.
        for (int i = 0; i < 7; i++) begin
            do_cycle(tbl[i].s, g);
            chk32("tbl_grant", 32'(g), 32'(tbl[i].eg));
            chk1("tbl_rvalid0", rvalid0, tbl[i].erv0);
            chk1("tbl_rvalid1", rvalid1, tbl[i].erv1);
            chk32("tbl_rd0", rd0, tbl[i].erd0);
            chk32("tbl_rd1", rd1, tbl[i].erd1);
        end
        chk32("mem5_dead", mem[5], 32'hDEAD);

`ifdef DMARB_LOCK_EN
        // Port 0 locks: LOCK_MAX grants, one grant to port 1, then relock.
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        st = mk(1, 0, 5, 0, 1, 0, 3, 0);
        st.l0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            do_cycle(st, g);
            chk32("lock_seq", 32'(g), 32'(exp_seq[i]));
        end
        do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), g);
`endif

        // Asynchronous reset in the middle of a locked sequence.
        st = mk(1, 0, 5, 0, 1, 0, 3, 0);
        st.l0 = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle(st, g);
        #2;
        we0 = 1'b1; addr0 = 6'd5; wd0 = 32'hBAD; RST = 1'b1;
        #1;
        chk1("arst_gnt0", gnt0, 1'b0);
        chk1("arst_gnt1", gnt1, 1'b0);
        chk1("arst_mem_WE", mem_WE, 1'b0);
        chk1("arst_rvalid0", rvalid0, 1'b0);
        chk32("arst_rd0", rd0, 32'h0);
        chk32("arst_rd1", rd1, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        chk32("arst_nowrite", mem[5], sh[5]);
        do_cycle(mk(1, 0, 5, 0, 1, 0, 3, 0), g);
        chk32("arst_first_contention", 32'(g), 32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            st.r0 = ($urandom_range(0, 9) < 7);
            st.w0 = 1'($urandom_range(0, 1));
            st.a0 = 6'($urandom_range(0, 7));
            st.d0 = $urandom();
            st.l0 = ($urandom_range(0, 3) != 0);
            st.r1 = ($urandom_range(0, 9) < 7);
            st.w1 = 1'($urandom_range(0, 1));
            st.a1 = 6'($urandom_range(0, 7));
            st.d1 = $urandom();
            st.l1 = ($urandom_range(0, 3) == 0);
            do_cycle(st, g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
